// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB first, one full-subtractor
// bit per clock, with a borrow flop chaining each cycle into the next.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] diffSh_q, diffSh_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diffOut_q, diffOut_d;
  logic             borrowOut_q, borrowOut_d;

  logic             cellDiff;
  logic             cellBout;
  logic [WIDTH:0]   diffShift;

  // The final bit is folded into the visible result on the same edge that
  // enters DONE, so the result registers see the complete difference.
  always_comb begin
    cellDiff    = aSh_q[0] ^ bSh_q[0] ^ borrow_q;
    cellBout    = (~aSh_q[0] & bSh_q[0]) | (~(aSh_q[0] ^ bSh_q[0]) & borrow_q);
    diffShift   = {cellDiff, diffSh_q};

    state_d     = state_q;
    aSh_d       = aSh_q;
    bSh_d       = bSh_q;
    diffSh_d    = diffSh_q;
    borrow_d    = borrow_q;
    cnt_d       = cnt_q;
    diffOut_d   = diffOut_q;
    borrowOut_d = borrowOut_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = BUSY;
          aSh_d    = a;
          bSh_d    = b;
          diffSh_d = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end else begin
          state_d  = IDLE;
        end
      end
      BUSY: begin
        aSh_d    = aSh_q >> 1;
        bSh_d    = bSh_q >> 1;
        diffSh_d = diffShift[WIDTH:1];
        borrow_d = cellBout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          diffOut_d   = diffShift[WIDTH:1];
          borrowOut_d = cellBout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      aSh_q       <= '0;
      bSh_q       <= '0;
      diffSh_q    <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      diffOut_q   <= '0;
      borrowOut_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      aSh_q       <= aSh_d;
      bSh_q       <= bSh_d;
      diffSh_q    <= diffSh_d;
      borrow_q    <= borrow_d;
      cnt_q       <= cnt_d;
      diffOut_q   <= diffOut_d;
      borrowOut_q <= borrowOut_d;
    end
  end

  assign busy       = (state_q == BUSY);
  assign done       = (state_q == DONE);
  assign diff       = diffOut_q;
  assign borrow_out = borrowOut_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8-bit instance checked through
// a result scoreboard, plus a 1-bit instance checked against a direct model.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8;
  logic [7:0] diff8;
  logic       bor8;

  logic       start1;
  logic [0:0] a1, b1;
  logic       busy1, done1;
  logic [0:0] diff1;
  logic       bor1;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       br;
  } exp_t;

  exp_t expQ[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expDiff;
    logic       expBorrow;
  } vec_t;

  vec_t vecs[5];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bor8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bor1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every done pulse of the 8-bit unit consumes one expected result.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      checkOutput("busyDoneExclusive", 32'(busy8), 32'd0);
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpectedDone: got done=1, expected no pending result");
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("diff", 32'(diff8), 32'(e.d));
        checkOutput("borrowOut", 32'(bor8), 32'(e.br));
      end
    end
  end

  // One isolated 8-bit op; reports busy cycles seen before the done pulse.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic [7:0] ed, input logic eb,
                               output int busyCycles, output bit gotDone);
    start8 = 1'b1;
    a8 = av;
    b8 = bv;
    expQ.push_back({ed, eb});
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    busyCycles = 0;
    gotDone = 1'b0;
    for (int i = 0; i < 40 && !gotDone; i++) begin
      @(negedge clk);
      if (done8) gotDone = 1'b1;
      else if (busy8) busyCycles++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  busyCycles;
    bit  gotDone;
    int  gap;
    int  busyInGap;
    int  doneSeen;
    logic [7:0] ra, rb;
    logic [1:0] r1;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vecs[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetBusy", 32'(busy8), 32'd0);
    checkOutput("resetDone", 32'(done8), 32'd0);
    checkOutput("resetDiff", 32'(diff8), 32'd0);
    checkOutput("resetBorrow", 32'(bor8), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] table-driven vectors");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].expDiff, vecs[i].expBorrow,
                    busyCycles, gotDone);
      checkOutput("doneArrived", 32'(gotDone), 32'd1);
      checkOutput("busyCycles", 32'(busyCycles), 32'd8);
    end

    $display("[TB] back-to-back with start held high");
    start8 = 1'b1;
    a8 = 8'h10;
    b8 = 8'h01;
    expQ.push_back({8'h0F, 1'b0});
    @(posedge clk);
    #1;
    a8 = 8'h01;
    b8 = 8'h10;
    expQ.push_back({8'hF1, 1'b1});
    doneSeen = 0;
    gap = 0;
    busyInGap = 0;
    for (int i = 0; i < 60 && doneSeen < 2; i++) begin
      @(negedge clk);
      if (doneSeen == 1) begin
        gap++;
        if (busy8) busyInGap++;
      end
      if (done8) begin
        doneSeen++;
        if (doneSeen == 1) begin
          @(posedge clk);
          #1;
          start8 = 1'b0;
          a8 = 8'h77;
          b8 = 8'h22;
        end
      end
    end
    checkOutput("b2bDoneCount", 32'(doneSeen), 32'd2);
    checkOutput("b2bDoneGap", 32'(gap), 32'd9);
    checkOutput("b2bBusyInGap", 32'(busyInGap), 32'd8);
    @(posedge clk);
    #1;

    $display("[TB] start and operand changes while busy");
    start8 = 1'b1;
    a8 = 8'h80;
    b8 = 8'h7F;
    expQ.push_back({8'h01, 1'b0});
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start8 = 1'b1;
    a8 = 8'hFF;
    b8 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    start8 = 1'b0;
    gotDone = 1'b0;
    for (int i = 0; i < 40 && !gotDone; i++) begin
      @(negedge clk);
      if (done8) gotDone = 1'b1;
    end
    checkOutput("ignoreDoneArrived", 32'(gotDone), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("ignoreNoExtraOp", 32'(busy8), 32'd0);

    $display("[TB] asynchronous reset mid-operation");
    start8 = 1'b1;
    a8 = 8'h33;
    b8 = 8'h11;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abortBusy", 32'(busy8), 32'd0);
    checkOutput("abortDone", 32'(done8), 32'd0);
    checkOutput("abortDiff", 32'(diff8), 32'd0);
    checkOutput("abortBorrow", 32'(bor8), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8 || busy8) doneSeen++;
    end
    checkOutput("noDoneAfterAbort", 32'(doneSeen), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] WIDTH=1 exhaustive");
    for (int i = 0; i < 4; i++) begin
      a1 = 1'(i >> 1);
      b1 = 1'(i);
      r1 = {1'b0, a1} - {1'b0, b1};
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      a1 = ~a1;
      b1 = ~b1;
      gotDone = 1'b0;
      busyCycles = 0;
      for (int k = 0; k < 10 && !gotDone; k++) begin
        @(negedge clk);
        if (done1) gotDone = 1'b1;
        else if (busy1) busyCycles++;
      end
      checkOutput("w1DoneArrived", 32'(gotDone), 32'd1);
      checkOutput("w1BusyCycles", 32'(busyCycles), 32'd1);
      checkOutput("w1Diff", 32'(diff1), 32'(r1[0]));
      checkOutput("w1Borrow", 32'(bor1), 32'(r1[1]));
      @(posedge clk);
      #1;
    end

    $display("[TB] random WIDTH=8 operations");
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = (i % 16 == 0) ? ra : 8'($urandom);
      applyStimulus(ra, rb, ra - rb, (ra < rb), busyCycles, gotDone);
      checkOutput("randDoneArrived", 32'(gotDone), 32'd1);
    end

    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
